mem_segment_param: RTL and testbench
====================================

Name: mem_segment_param

Overview:
- Parametrised successor to the fixed 16-word x 16-bit data-memory sub-segment.
- Generalised in width (DATA_WIDTH) and depth (2^ADDR_WIDTH words). Adds byte-enable writes, a registered read with a valid strobe, and a REQ/READY handshake.
- Adds a hardware clear sweep that runs after reset and on command. The sweep fills every word with FILL_VALUE, one word per cycle.
- Sits in the data memory as the building block for segments. The segment decoder drives REQ_SEG and ADDR_SEG.

Parameters:
- DATA_WIDTH, 16: word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 4: address width. Depth DEPTH = 2^ADDR_WIDTH words.
- FILL_VALUE, 0: DATA_WIDTH-bit value written to every word during a clear sweep.

Ports:
- CLK_SEG  input  1  clock; all state changes on the rising edge.
- RST_N_SEG  input  1  reset, asynchronous, active-low.
- REQ_SEG  input  1  request valid.
- WE_SEG  input  1  1 = write, 0 = read. Sampled with REQ_SEG.
- BE_SEG  input  DATA_WIDTH/8  byte enables for writes. Bit i covers bits [8i+7:8i].
- ADDR_SEG  input  ADDR_WIDTH  word address.
- DATA_IN_SEG  input  DATA_WIDTH  write data.
- CLR_SEG  input  1  clear command, level-sampled each cycle.
- READY_SEG  output  1  segment can accept a request this cycle.
- DATA_OUT_SEG  output  DATA_WIDTH  registered read data.
- VALID_SEG  output  1  one-cycle strobe: DATA_OUT_SEG holds new read data.
- BUSY_SEG  output  1  clear sweep in progress.

Behaviour:
- Reset (RST_N_SEG=0, asynchronous):
  - State = CLEAR, sweep counter = 0.
  - VALID_SEG=0, DATA_OUT_SEG=0, BUSY_SEG=1, READY_SEG=0.
  - Storage array has no reset; it is initialised by the sweep.
- States: CLEAR, IDLE.
- CLEAR state:
  - Each cycle, word[counter] <= FILL_VALUE and counter increments.
  - In the cycle counter == DEPTH-1, the last word is written and the next state is IDLE.
  - A sweep takes exactly DEPTH cycles after reset release. BUSY_SEG=1 throughout.
  - REQ_SEG is ignored.
  - CLR_SEG=1 during CLEAR restarts the counter at 0.
- IDLE state:
  - BUSY_SEG=0.
  - READY_SEG = ~CLR_SEG (combinational).
  - CLR_SEG=1 moves to CLEAR at the next edge, counter = 0. Any REQ_SEG in that cycle is not accepted.
- Acceptance: a request is accepted when REQ_SEG & READY_SEG. At most one request per cycle, so simultaneous read and write cannot occur.
- Write:
  - Each byte i with BE_SEG[i]=1 is updated from DATA_IN_SEG at the accepting edge. Other bytes are unchanged.
  - BE_SEG=0 is accepted and changes nothing.
  - VALID_SEG is not asserted.
- Read:
  - DATA_OUT_SEG <= word[ADDR_SEG] at the accepting edge. VALID_SEG=1 for exactly the following cycle.
  - Latency is 1.
  - DATA_OUT_SEG holds its last value otherwise, including across a clear sweep.
- Read-after-write: a read accepted the cycle after a write to the same address returns the written data.
- Back-to-back reads: full throughput, one per cycle, VALID_SEG held high continuously.
- Wrap-around: ADDR_SEG covers exactly DEPTH words, so no out-of-range access exists. The sweep counter never exceeds DEPTH-1.
- Reset mid-operation (any state): behaves exactly as the initial reset. A pending VALID_SEG is dropped and a full sweep follows.
- Widths: internal sweep counter is ADDR_WIDTH bits. No arithmetic on data.

Test Plan:
1. Reset release, DATA_WIDTH=16, ADDR_WIDTH=4, FILL_VALUE=16'h0000:
   - BUSY_SEG=1 for 16 cycles, then READY_SEG=1.
   - Reads of addresses 0..15 each return 16'h0000 with VALID_SEG one cycle after acceptance.
2. Write 16'hA5C3 to address 7 with BE_SEG=2'b11, then a write of 16'hFFFF to address 7 with BE_SEG=2'b01, then read address 7:
   - The read returns 16'hA5FF.
   - A read of address 6 returns 16'h0000.
3. Writes to addresses 0..15 with data 16'h1000+addr, then 16 back-to-back reads:
   - VALID_SEG is high for 16 consecutive cycles.
   - Data is 16'h1000..16'h100F in order.
4. CLR_SEG pulsed together with REQ_SEG read in IDLE:
   - READY_SEG=0 in that cycle and no VALID_SEG follows.
   - BUSY_SEG=1 for 16 cycles.
   - Previously written words then read back as FILL_VALUE.
5. RST_N_SEG asserted mid-sweep (counter=9) and mid-read (VALID_SEG pending):
   - Outputs return to reset values immediately.
   - A full 16-cycle sweep restarts after release.
6. Re-parameterise DATA_WIDTH=32, ADDR_WIDTH=6, FILL_VALUE=32'hDEADBEEF:
   - Sweep lasts 64 cycles.
   - Write 32'h12345678 to address 63 with BE_SEG=4'b1010; the read returns 32'h12AD56EF.

Source files
------------

// File: rtl/mem_segment_param.sv
// Parametrised data-memory segment: byte-enable writes, registered reads with a
// valid strobe, REQ/READY handshake and a FILL_VALUE clear sweep after reset or on command.
`timescale 1ns/1ps
module mem_segment_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                    CLK_SEG,
  input  logic                    RST_N_SEG,
  input  logic                    REQ_SEG,
  input  logic                    WE_SEG,
  input  logic [DATA_WIDTH/8-1:0] BE_SEG,
  input  logic [ADDR_WIDTH-1:0]   ADDR_SEG,
  input  logic [DATA_WIDTH-1:0]   DATA_IN_SEG,
  input  logic                    CLR_SEG,
  output logic                    READY_SEG,
  output logic [DATA_WIDTH-1:0]   DATA_OUT_SEG,
  output logic                    VALID_SEG,
  output logic                    BUSY_SEG
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  sweep_we;

  // A clear command in IDLE blocks acceptance in the same cycle.
  assign READY_SEG = (state_reg == IDLE) & ~CLR_SEG;
  assign rd_accept = REQ_SEG & READY_SEG & ~WE_SEG;
  assign wr_accept = REQ_SEG & READY_SEG & WE_SEG;
  assign sweep_we  = (state_reg == CLEAR);
  assign VALID_SEG = valid_reg;
  assign BUSY_SEG  = busy_reg;

  always_ff @(posedge CLK_SEG or negedge RST_N_SEG) begin
    if (!RST_N_SEG) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      valid_reg <= rd_accept;
      if (state_reg == CLEAR) begin
        if (CLR_SEG) begin
          cnt_reg <= '0;
        end else begin
          // Counter wraps to zero naturally on the final word.
          cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
          if (&cnt_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
      end else begin
        if (CLR_SEG) begin
          state_reg <= CLEAR;
          cnt_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      end
    end
  end

  // One narrow RAM per byte lane so byte enables map onto plain lane write enables.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [7:0]            mem [DEPTH];
    logic [7:0]            rd_reg;
    logic                  lane_we;
    logic [ADDR_WIDTH-1:0] lane_addr;
    logic [7:0]            lane_wdata;

    assign lane_we    = sweep_we | (wr_accept & BE_SEG[gi]);
    assign lane_addr  = sweep_we ? cnt_reg : ADDR_SEG;
    assign lane_wdata = sweep_we ? FILL_VALUE[8*gi +: 8] : DATA_IN_SEG[8*gi +: 8];

    always_ff @(posedge CLK_SEG) begin
      if (lane_we) begin
        mem[lane_addr] <= lane_wdata;
      end
    end

    always_ff @(posedge CLK_SEG or negedge RST_N_SEG) begin
      if (!RST_N_SEG) begin
        rd_reg <= '0;
      end else if (rd_accept) begin
        rd_reg <= mem[ADDR_SEG];
      end
    end

    assign DATA_OUT_SEG[8*gi +: 8] = rd_reg;
  end

endmodule

// File: tb/tb_mem_segment_param.sv
// Directed bench for mem_segment_param: default 16x16 instance plus a 32-bit x 64-word instance.
`timescale 1ns/1ps
module tb_mem_segment_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst_n, req, we, clr, ready, valid, busy;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din, dout;

  logic        rst_n_b, req_b, we_b, clr_b, ready_b, valid_b, busy_b;
  logic [3:0]  be_b;
  logic [5:0]  addr_b;
  logic [31:0] din_b, dout_b;

  mem_segment_param dut_a (
    .CLK_SEG(clk), .RST_N_SEG(rst_n), .REQ_SEG(req), .WE_SEG(we), .BE_SEG(be),
    .ADDR_SEG(addr), .DATA_IN_SEG(din), .CLR_SEG(clr), .READY_SEG(ready),
    .DATA_OUT_SEG(dout), .VALID_SEG(valid), .BUSY_SEG(busy)
  );

  mem_segment_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .FILL_VALUE(32'hDEADBEEF)) dut_b (
    .CLK_SEG(clk), .RST_N_SEG(rst_n_b), .REQ_SEG(req_b), .WE_SEG(we_b), .BE_SEG(be_b),
    .ADDR_SEG(addr_b), .DATA_IN_SEG(din_b), .CLR_SEG(clr_b), .READY_SEG(ready_b),
    .DATA_OUT_SEG(dout_b), .VALID_SEG(valid_b), .BUSY_SEG(busy_b)
  );

  // Called at a negedge; presents one request for one cycle and returns at the next negedge.
  task automatic issue(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    req = 1'b1; we = w; addr = a; din = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    $display("%s addr=%0d din=%h be=%b -> dout=%h valid=%b", w ? "WR" : "RD", a, d, b, dout, valid);
  endtask

  task automatic test_reset();
    int cycles;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || valid !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ready=%b valid=%b dout=%h, required 1 0 0 0000", busy, ready, valid, dout);
    end
    rst_n = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin @(negedge clk); cycles++; end
    checks++;
    if (cycles != 16 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep: busy cycles=%0d ready=%b, required 16 1", cycles, ready);
    end
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, 4'(a), 16'h0, 2'b00);
      checks++;
      if (valid !== 1'b1 || dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_read[%0d]: valid=%b dout=%h, required 1 0000", a, valid, dout);
      end
    end
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 4'd7, 16'hA5C3, 2'b11);
    issue(1'b1, 4'd7, 16'hFFFF, 2'b01);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_valid: valid=%b, required 0", valid);
    end
    issue(1'b0, 4'd7, 16'h0, 2'b00);
    checks++;
    if (valid !== 1'b1 || dout !== 16'hA5FF) begin
      errors++;
      $display("FAIL be_read7: valid=%b dout=%h, required 1 a5ff", valid, dout);
    end
    issue(1'b0, 4'd6, 16'h0, 2'b00);
    checks++;
    if (valid !== 1'b1 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL be_read6: valid=%b dout=%h, required 1 0000", valid, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int a = 0; a < 16; a++) issue(1'b1, 4'(a), 16'h1000 + 16'(a), 2'b11);
    req = 1'b1; we = 1'b0; addr = 4'd0;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      exp = 16'h1000 + 16'(a);
      $display("RD b2b addr=%0d -> dout=%h valid=%b", a, dout, valid);
      checks++;
      if (valid !== 1'b1 || dout !== exp) begin
        errors++;
        $display("FAIL b2b_read[%0d]: valid=%b dout=%h, required 1 %h", a, valid, dout, exp);
      end
      if (a < 15) addr = 4'(a + 1);
      else req = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b, required 0", valid);
    end
  endtask

  task automatic test_clear_cmd();
    int cycles;
    clr = 1'b1; req = 1'b1; we = 1'b0; addr = 4'd3;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: ready=%b, required 0", ready);
    end
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_start: valid=%b busy=%b, required 0 1", valid, busy);
    end
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin @(negedge clk); cycles++; end
    checks++;
    if (cycles != 16) begin
      errors++;
      $display("FAIL clr_sweep: busy cycles=%0d, required 16", cycles);
    end
    checks++;
    if (dout !== 16'h100F) begin
      errors++;
      $display("FAIL clr_dout_hold: dout=%h, required 100f", dout);
    end
    issue(1'b0, 4'd7, 16'h0, 2'b00);
    checks++;
    if (valid !== 1'b1 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL clr_read7: valid=%b dout=%h, required 1 0000", valid, dout);
    end
    issue(1'b0, 4'd15, 16'h0, 2'b00);
    checks++;
    if (valid !== 1'b1 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL clr_read15: valid=%b dout=%h, required 1 0000", valid, dout);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    issue(1'b1, 4'd2, 16'h1234, 2'b11);
    issue(1'b0, 4'd2, 16'h0, 2'b00);
    checks++;
    if (dout !== 16'h1234) begin
      errors++;
      $display("FAIL mid_preload: dout=%h, required 1234", dout);
    end
    // Start a sweep and abort it with reset when the counter reaches 9.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || valid !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL mid_sweep_reset: busy=%b ready=%b valid=%b dout=%h, required 1 0 0 0000", busy, ready, valid, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin @(negedge clk); cycles++; end
    checks++;
    if (cycles != 16) begin
      errors++;
      $display("FAIL mid_sweep_restart: busy cycles=%0d, required 16", cycles);
    end
    // Reset while a read's VALID is pending.
    issue(1'b1, 4'd5, 16'hBEEF, 2'b11);
    req = 1'b1; we = 1'b0; addr = 4'd5;
    @(posedge clk);
    #1;
    req = 1'b0;
    checks++;
    if (valid !== 1'b1 || dout !== 16'hBEEF) begin
      errors++;
      $display("FAIL mid_read_pending: valid=%b dout=%h, required 1 beef", valid, dout);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || valid !== 1'b0 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL mid_read_reset: busy=%b ready=%b valid=%b dout=%h, required 1 0 0 0000", busy, ready, valid, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin @(negedge clk); cycles++; end
    checks++;
    if (cycles != 16) begin
      errors++;
      $display("FAIL mid_read_restart: busy cycles=%0d, required 16", cycles);
    end
    issue(1'b0, 4'd5, 16'h0, 2'b00);
    checks++;
    if (valid !== 1'b1 || dout !== 16'h0000) begin
      errors++;
      $display("FAIL mid_read5: valid=%b dout=%h, required 1 0000", valid, dout);
    end
    // CLR during a sweep restarts the counter: 6 cycles + 16 cycles.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      if (cycles == 5) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cycles++;
    end
    checks++;
    if (cycles != 22) begin
      errors++;
      $display("FAIL clr_restart: busy cycles=%0d, required 22", cycles);
    end
  endtask

  task automatic test_param32();
    int cycles;
    checks++;
    if (busy_b !== 1'b1 || ready_b !== 1'b0 || valid_b !== 1'b0 || dout_b !== 32'h0) begin
      errors++;
      $display("FAIL w32_reset: busy=%b ready=%b valid=%b dout=%h, required 1 0 0 00000000", busy_b, ready_b, valid_b, dout_b);
    end
    rst_n_b = 1'b1;
    cycles = 0;
    while (busy_b === 1'b1 && cycles < 300) begin @(negedge clk); cycles++; end
    checks++;
    if (cycles != 64 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL w32_sweep: busy cycles=%0d ready=%b, required 64 1", cycles, ready_b);
    end
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'd63; din_b = 32'h12345678; be_b = 4'b1010;
    @(negedge clk);
    $display("WR w32 addr=63 din=12345678 be=1010");
    we_b = 1'b0;
    @(negedge clk);
    req_b = 1'b0;
    $display("RD w32 addr=63 -> dout=%h valid=%b", dout_b, valid_b);
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 32'h12AD56EF) begin
      errors++;
      $display("FAIL w32_read63: valid=%b dout=%h, required 1 12ad56ef", valid_b, dout_b);
    end
    req_b = 1'b1; addr_b = 6'd0;
    @(negedge clk);
    req_b = 1'b0;
    $display("RD w32 addr=0 -> dout=%h valid=%b", dout_b, valid_b);
    checks++;
    if (valid_b !== 1'b1 || dout_b !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL w32_read0: valid=%b dout=%h, required 1 deadbeef", valid_b, dout_b);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0; be = '0; addr = '0; din = '0;
    rst_n_b = 1'b0; req_b = 1'b0; we_b = 1'b0; clr_b = 1'b0; be_b = '0; addr_b = '0; din_b = '0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear_cmd();
    test_reset_mid();
    test_param32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
